// File: rtl/div_bcd_out.sv
// Converts a divider's binary quotient (and optionally remainder) to 3-digit BCD via double-dabble.
// Optional build macro: DIV_BCD_REM_EN enables remainder conversion; otherwise r_bcd is tied to zero.
module div_bcd_out (
    input  logic        clk,
    input  logic        rst,
    input  logic        done,
    input  logic [7:0]  res,
    input  logic [7:0]  rem,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] q_bcd,
    output logic [11:0] r_bcd,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t      state, state_nxt;
    logic        capture, step, finish, drop;
    logic [3:0]  cnt;
    logic [7:0]  q_sh;
    logic [11:0] q_acc, q_acc_nxt;

    // One double-dabble iteration: correct every digit >= 5, then shift in the next binary bit.
    function automatic logic [11:0] dabble(input logic [11:0] acc, input logic bit_in);
        logic [11:0] adj;
        for (int d = 0; d < 3; d++)
            adj[4*d +: 4] = (acc[4*d +: 4] >= 4'd5) ? acc[4*d +: 4] + 4'd3 : acc[4*d +: 4];
        return {adj[10:0], bit_in};
    endfunction

    assign q_acc_nxt = dabble(q_acc, q_sh[7]);
    assign busy      = (state != IDLE);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (done) begin
                    capture   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                drop = done;
                if (cnt == 4'd1) begin
                    finish    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (done) begin
                        capture   = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    drop = done;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 4'd0;
            q_sh    <= 8'd0;
            q_acc   <= 12'd0;
            q_bcd   <= 12'd0;
            overrun <= 1'b0;
        end else begin
            if (capture) begin
                q_sh  <= res;
                q_acc <= 12'd0;
                cnt   <= 4'd8;
            end else if (step) begin
                q_sh  <= {q_sh[6:0], 1'b0};
                q_acc <= q_acc_nxt;
                cnt   <= cnt - 4'd1;
            end
            if (finish) q_bcd   <= q_acc_nxt;
            if (drop)   overrun <= 1'b1;
        end
    end

`ifdef DIV_BCD_REM_EN
    logic [7:0]  r_sh;
    logic [11:0] r_acc, r_acc_nxt, r_bcd_q;

    assign r_acc_nxt = dabble(r_acc, r_sh[7]);
    assign r_bcd     = r_bcd_q;

    // Remainder path shares the quotient's control strobes, so latency is identical.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh    <= 8'd0;
            r_acc   <= 12'd0;
            r_bcd_q <= 12'd0;
        end else begin
            if (capture) begin
                r_sh  <= rem;
                r_acc <= 12'd0;
            end else if (step) begin
                r_sh  <= {r_sh[6:0], 1'b0};
                r_acc <= r_acc_nxt;
            end
            if (finish) r_bcd_q <= r_acc_nxt;
        end
    end
`else
    logic rem_unused;
    assign rem_unused = ^rem;
    assign r_bcd      = 12'h000;
`endif

endmodule

// File: tb/tb_div_bcd_out.sv
// Self-checking bench for div_bcd_out; expected BCD comes from decimal arithmetic on the operands.
module tb_div_bcd_out;

    logic        clk = 1'b0;
    logic        rst, done, out_ready;
    logic [7:0]  res, rem;
    logic        busy, out_valid, overrun;
    logic [11:0] q_bcd, r_bcd;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_q, exp_r;

    div_bcd_out dut (
        .clk(clk), .rst(rst), .done(done), .res(res), .rem(rem),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .q_bcd(q_bcd), .r_bcd(r_bcd), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [11:0] rem_bcd(input int v);
`ifdef DIV_BCD_REM_EN
        return to_bcd(v);
`else
        return 12'h000 + 12'(v & 0);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [7:0] a, input logic [7:0] b);
        done = 1'b1; res = a; rem = b;
        tick();
        done = 1'b0; res = 8'($urandom); rem = 8'($urandom);
    endtask

    // Follows a capture edge: 7 quiet SHIFT edges, then the 8th presents the result.
    task automatic finish_conv(input string tag, input logic [7:0] a, input logic [7:0] b);
        check({tag, "/busy0"}, busy, 1);
        check({tag, "/valid0"}, out_valid, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check({tag, "/valid_shift"}, out_valid, 0);
            check({tag, "/q_shift"}, q_bcd, exp_q);
        end
        tick();
        exp_q = to_bcd(a);
        exp_r = rem_bcd(b);
        check({tag, "/valid"}, out_valid, 1);
        check({tag, "/q"}, q_bcd, exp_q);
        check({tag, "/r"}, r_bcd, exp_r);
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "/acc_valid"}, out_valid, 0);
        check({tag, "/acc_busy"}, busy, 0);
        check({tag, "/acc_q"}, q_bcd, exp_q);
    endtask

    initial begin
        logic [7:0] a, b;
        rst = 1'b1; done = 1'b0; out_ready = 1'b0; res = 8'd0; rem = 8'd0;
        exp_q = 12'h000; exp_r = 12'h000;
        tick(); tick();
        check("reset/busy", busy, 0);
        check("reset/valid", out_valid, 0);
        check("reset/q", q_bcd, 0);
        check("reset/r", r_bcd, 0);
        check("reset/overrun", overrun, 0);
        rst = 1'b0;
        tick();

        // out_ready with nothing pending does nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_ready/busy", busy, 0);
        check("idle_ready/valid", out_valid, 0);

        capture(8'd3, 8'd2);
        finish_conv("small", 8'd3, 8'd2);
        accept("small");

        // Max value held under backpressure
        capture(8'd255, 8'd199);
        finish_conv("max", 8'd255, 8'd199);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("max_hold/valid", out_valid, 1);
            check("max_hold/q", q_bcd, 12'h255);
            check("max_hold/r", r_bcd, rem_bcd(199));
        end
        accept("max");

        for (int n = 0; n < 16; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            capture(a, b);
            finish_conv("rand", a, b);
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                tick();
                check("rand_hold/valid", out_valid, 1);
            end
            accept("rand");
        end
        check("rand/overrun", overrun, 0);

        // Back-to-back: new done accepted together with out_ready
        a = 8'($urandom); b = 8'($urandom);
        capture(a, b);
        finish_conv("b2b_first", a, b);
        b = 8'($urandom);
        done = 1'b1; res = 8'd100; rem = b; out_ready = 1'b1;
        tick();
        done = 1'b0; out_ready = 1'b0;
        check("b2b/q_prev", q_bcd, exp_q);
        check("b2b/overrun", overrun, 0);
        finish_conv("b2b_second", 8'd100, b);
        check("b2b/q100", q_bcd, 12'h100);
        check("b2b/overrun_end", overrun, 0);
        accept("b2b");

        // Done dropped 3 edges into SHIFT, then again in HOLD without ready
        a = 8'($urandom); b = 8'($urandom);
        capture(a, b);
        tick(); tick(); tick();
        done = 1'b1; res = ~a; rem = ~b;
        tick();
        done = 1'b0;
        check("ovr/flag", overrun, 1);
        check("ovr/busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ovr/valid_shift", out_valid, 0);
        end
        tick();
        exp_q = to_bcd(a); exp_r = rem_bcd(b);
        check("ovr/valid", out_valid, 1);
        check("ovr/q", q_bcd, exp_q);
        check("ovr/r", r_bcd, exp_r);
        done = 1'b1; res = 8'd7;
        tick();
        done = 1'b0;
        check("ovr_hold/valid", out_valid, 1);
        check("ovr_hold/q", q_bcd, exp_q);
        accept("ovr");
        check("ovr/sticky", overrun, 1);

        // Reset on the 5th SHIFT step, with a coincident done
        capture(8'($urandom), 8'($urandom));
        tick(); tick(); tick(); tick();
        rst = 1'b1; done = 1'b1; res = 8'd42;
        tick();
        rst = 1'b0; done = 1'b0;
        exp_q = 12'h000; exp_r = 12'h000;
        check("rst_mid/busy", busy, 0);
        check("rst_mid/valid", out_valid, 0);
        check("rst_mid/q", q_bcd, 0);
        check("rst_mid/r", r_bcd, 0);
        check("rst_mid/overrun", overrun, 0);
        tick();
        check("rst_mid/done_dropped", busy, 0);
        capture(8'd0, 8'd0);
        finish_conv("zero", 8'd0, 8'd0);
        check("zero/q", q_bcd, 12'h000);
        accept("zero");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_bcd_out.md
DIV_BCD_OUT -- requirements
Module: div_bcd_out

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 done  input  1  one-cycle completion pulse from the divider; qualifies res and rem.
REQ-005 res  input  8  divider quotient, binary unsigned.
REQ-006 rem  input  8  divider remainder, binary unsigned.
REQ-007 busy  output  1  high whenever the FSM is not in IDLE.
REQ-008 out_valid  output  1  BCD results valid; held until accepted.
REQ-009 out_ready  input  1  consumer accepts results when high with out_valid.
REQ-010 q_bcd  output  12  quotient as 3 BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-011 r_bcd  output  12  remainder as 3 BCD digits, same layout.
REQ-012 overrun  output  1  sticky flag: a done pulse was dropped.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, HOLD.
REQ-014 In IDLE, done=1 on a rising edge SHALL capture res/rem into shift registers, clear the BCD accumulators, load an iteration counter with 8, and enter SHIFT.
REQ-015 In SHIFT, each edge SHALL perform one double-dabble step: add 3 to every accumulator digit >= 5, then shift left by one, taking in the binary MSB.
REQ-016 On the edge that completes the 8th step, the FSM SHALL enter HOLD and assert out_valid; out_valid is therefore first high 8 cycles after the capture edge.
REQ-017 In HOLD, q_bcd/r_bcd/out_valid SHALL remain stable until out_ready=1 is sampled; on that edge the FSM SHALL return to IDLE and deassert out_valid.
REQ-018 q_bcd/r_bcd SHALL hold their last completed value in IDLE and SHALL NOT be presented mid-conversion; during SHIFT they show the previous result.
REQ-019 In HOLD, if done=1 on the same edge out_ready=1 is accepted, the new operands SHALL be captured and the FSM SHALL go directly to SHIFT, with no overrun.
REQ-020 A done=1 sampled in SHIFT, or in HOLD without an accepting out_ready, SHALL be ignored and SHALL set overrun.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 Every BCD digit SHALL be 0..9; 255 converts to 0x255 and 0 converts to 0x000.
REQ-023 busy SHALL be high in SHIFT and HOLD and low in IDLE.

Reset
REQ-024 rst=1 on an edge SHALL force IDLE, out_valid=0, busy=0, q_bcd=0, r_bcd=0, overrun=0, and counter=0, overriding any other input, including mid-SHIFT or in HOLD.
REQ-025 A done pulse coincident with rst SHALL be discarded.
REQ-026 overrun SHALL be cleared only by reset.

Configuration
REQ-027 Macro DIV_BCD_REM_EN SHALL select whether the remainder is converted.
REQ-028 With DIV_BCD_REM_EN defined, rem SHALL be captured and converted in parallel with res, with identical latency.
REQ-029 Without DIV_BCD_REM_EN, rem SHALL be unused, no remainder registers SHALL exist, and r_bcd SHALL be constant 12'h000.
REQ-030 Quotient timing and handshake SHALL be identical in both builds.

Verification
REQ-031 done pulse with res=3, rem=2 -> out_valid on the 8th edge after capture; q_bcd=0x003; r_bcd=0x002 (0x000 without the macro).
REQ-032 res=255, rem=199, out_ready held low for 20 cycles -> q_bcd=0x255 and r_bcd=0x199 stay stable with out_valid=1; the FSM leaves HOLD on the first edge where out_ready=1.
REQ-033 Second done pulse 3 cycles into SHIFT -> pulse ignored, overrun=1, first result unchanged.
REQ-034 In HOLD, done (res=100) coincident with out_ready=1 -> first result accepted, new conversion starts, overrun=0, q_bcd=0x100 eight edges later.
REQ-035 rst=1 asserted at step 5 of SHIFT -> next cycle IDLE, all outputs 0; a fresh done with res=0 yields q_bcd=0x000.
